// File: rtl/hmmm_program_loader.sv
// Serial program loader for the hmmm core: deserialises address/data frames from
// the programming pins and owns the instruction-memory write port while loading.
module hmmm_program_loader #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pgrm_addr,
   input  logic              pgrm_data,
   input  logic              cpu_idle,
   input  logic              mem_ready,
   output logic              cpu_hold,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              frame_err,
   output logic [7:0]        words_loaded
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int TO_W    = $clog2(TIMEOUT);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W);
   localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] CMD_ADDR  = '1;
   localparam logic [DATA_W-1:0] CMD_START = DATA_W'(1);
   localparam logic [DATA_W-1:0] CMD_STOP  = '0;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      SHIFT,
      WAIT_IDLE,
      WRITE
   } state_t;

   state_t             state;
   logic               addr_s1, addr_s2, addr_s3;
   logic               data_s1, data_s2;
   logic               ser_edge;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   bitcnt;
   logic [TO_W-1:0]    tcnt;
   logic [ADDR_W-1:0]  frame_addr;
   logic [DATA_W-1:0]  frame_data;

   // Pad signals are asynchronous; the third address flop only serves edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_s1 <= 1'b0;
         addr_s2 <= 1'b0;
         addr_s3 <= 1'b0;
         data_s1 <= 1'b0;
         data_s2 <= 1'b0;
      end else begin
         addr_s1 <= pgrm_addr;
         addr_s2 <= addr_s1;
         addr_s3 <= addr_s2;
         data_s1 <= pgrm_data;
         data_s2 <= data_s1;
      end
   end

   assign ser_edge   = addr_s2 & ~addr_s3;
   assign frame_addr = shreg[FRAME_W-1:DATA_W];
   assign frame_data = shreg[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cpu_hold     <= 1'b1;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         frame_err    <= 1'b0;
         words_loaded <= '0;
         shreg        <= '0;
         bitcnt       <= '0;
         tcnt         <= '0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (ser_edge) begin
                  shreg    <= {{(FRAME_W-1){1'b0}}, data_s2};
                  bitcnt   <= CNT_W'(1);
                  tcnt     <= '0;
                  cpu_hold <= 1'b1;
                  state    <= SHIFT;
               end
            end

            SHIFT: begin
               if (bitcnt == LAST_BIT) begin
                  // A bit arriving while the full frame is being decoded has nowhere to go.
                  if (ser_edge) begin
                     frame_err <= 1'b1;
                  end
                  bitcnt <= '0;
                  if (frame_addr == CMD_ADDR) begin
                     if (frame_data == CMD_START) begin
                        cpu_hold <= 1'b0;
                        state    <= RUN;
                     end else if (frame_data == CMD_STOP) begin
                        state <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                     end
                  end else begin
                     mem_addr  <= frame_addr;
                     mem_wdata <= frame_data;
                     state     <= WAIT_IDLE;
                  end
               end else if (ser_edge) begin
                  shreg  <= {shreg[FRAME_W-2:0], data_s2};
                  bitcnt <= bitcnt + CNT_W'(1);
                  tcnt   <= '0;
               end else if (tcnt == TO_LIMIT) begin
                  frame_err <= 1'b1;
                  shreg     <= '0;
                  bitcnt    <= '0;
                  tcnt      <= '0;
                  state     <= IDLE;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end

            WAIT_IDLE: begin
               if (ser_edge) begin
                  frame_err <= 1'b1;
               end
               if (cpu_idle) begin
                  mem_we <= 1'b1;
                  state  <= WRITE;
               end
            end

            WRITE: begin
               if (ser_edge) begin
                  frame_err <= 1'b1;
               end
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  if (words_loaded != 8'hFF) begin
                     words_loaded <= words_loaded + 8'd1;
                  end
                  state <= IDLE;
               end
            end

            default: begin
               mem_we   <= 1'b0;
               cpu_hold <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hmmm_program_loader.sv
// Self-checking bench for hmmm_program_loader: vector table, hand-written corner
// sequences and randomized frames compared against a frame-level reference model.
module tb_hmmm_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pgrm_addr = 1'b0;
   logic        pgrm_data = 1'b0;
   logic        cpu_idle = 1'b1;
   logic        mem_ready = 1'b0;
   logic        cpu_hold;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        frame_err;
   logic [7:0]  words_loaded;

   int tests_run = 0;
   int tests_failed = 0;

   int ready_delay = 0;
   int we_run = 0;
   int we_total = 0;
   int err_count = 0;
   int stable_bad = 0;
   int hold_bad = 0;
   int model_words = 0;
   int err_before = 0;

   logic [7:0]  cap_addr = '0;
   logic [15:0] cap_data = '0;
   logic [7:0]  wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   int          wr_len_q[$];

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      int          rd;
      int          idl;
      logic        exp_hold;
      logic        exp_write;
      int          exp_err;
   } vec_t;

   vec_t vecs[8];

   hmmm_program_loader #(
      .ADDR_W(8),
      .DATA_W(16),
      .TIMEOUT(1024)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pgrm_addr(pgrm_addr),
      .pgrm_data(pgrm_data),
      .cpu_idle(cpu_idle),
      .mem_ready(mem_ready),
      .cpu_hold(cpu_hold),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .frame_err(frame_err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Memory responder and write monitor, sampling just after the falling edge.
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         we_run    = 0;
         mem_ready = 1'b0;
      end else begin
         if (mem_we) begin
            if (we_run == 0) begin
               cap_addr = mem_addr;
               cap_data = mem_wdata;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_data) begin
               stable_bad++;
            end
            if (cpu_hold !== 1'b1) hold_bad++;
            we_run++;
            we_total++;
            mem_ready = (we_run > ready_delay);
         end else begin
            if (we_run != 0) begin
               wr_addr_q.push_back(cap_addr);
               wr_data_q.push_back(cap_data);
               wr_len_q.push_back(we_run);
            end
            we_run    = 0;
            mem_ready = 1'b0;
         end
         if (frame_err === 1'b1) err_count++;
      end
   end

   // Reference model: 0 write, 1 start, 2 stop, 3 bad command.
   function automatic int frameKind(input logic [7:0] a, input logic [15:0] d);
      if (a != 8'hFF) return 0;
      if (d == 16'd1) return 1;
      if (d == 16'd0) return 2;
      return 3;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic sendBits(input logic [23:0] bits, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         @(negedge clk);
         pgrm_addr = 1'b0;
         pgrm_data = bits[i];
         repeat (2) @(negedge clk);
         pgrm_addr = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d, input int rd, input int idl);
      int we_before;
      ready_delay = rd;
      if (idl > 0) cpu_idle = 1'b0;
      sendBits({a, d}, 23, 0);
      if (idl > 0) begin
         we_before = we_total;
         repeat (idl) @(negedge clk);
         checkOutput("stall_no_we", we_total - we_before, 0);
         cpu_idle = 1'b1;
      end
      repeat (rd + 12) @(negedge clk);
   endtask

   task automatic clearWrites();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_len_q.delete();
   endtask

   task automatic expectWrite(input string tag, input logic [7:0] a, input logic [15:0] d, input int len);
      checkOutput({tag, "_count"}, wr_addr_q.size(), 1);
      if (wr_addr_q.size() > 0) begin
         checkOutput({tag, "_addr"}, wr_addr_q[0], a);
         checkOutput({tag, "_data"}, wr_data_q[0], d);
         checkOutput({tag, "_len"}, wr_len_q[0], len);
      end
      clearWrites();
      if (model_words < 255) model_words++;
      checkOutput({tag, "_words"}, words_loaded, model_words);
   endtask

   task automatic expectNoWrite(input string tag);
      checkOutput({tag, "_nowrite"}, wr_addr_q.size(), 0);
      clearWrites();
      checkOutput({tag, "_words"}, words_loaded, model_words);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      pgrm_addr = 1'b0;
      pgrm_data = 1'b0;
      cpu_idle  = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput({tag, "_hold"}, cpu_hold, 1);
      checkOutput({tag, "_we"}, mem_we, 0);
      checkOutput({tag, "_addr"}, mem_addr, 0);
      checkOutput({tag, "_wdata"}, mem_wdata, 0);
      checkOutput({tag, "_err"}, frame_err, 0);
      checkOutput({tag, "_words"}, words_loaded, 0);
      rst_n       = 1'b1;
      model_words = 0;
      repeat (3) @(negedge clk);
      clearWrites();
   endtask

   initial begin
      logic [7:0]  ra;
      logic [15:0] rdat;
      int          rrd, ridl, kind, n;

      vecs[0] = '{8'h05, 16'hA1B2, 0, 0,  1'b1, 1'b1, 0};
      vecs[1] = '{8'h05, 16'hA1B2, 7, 0,  1'b1, 1'b1, 0};
      vecs[2] = '{8'h22, 16'hBEEF, 2, 20, 1'b1, 1'b1, 0};
      vecs[3] = '{8'hFF, 16'h0042, 0, 0,  1'b1, 1'b0, 1};
      vecs[4] = '{8'hFF, 16'h0001, 0, 0,  1'b0, 1'b0, 0};
      vecs[5] = '{8'hFF, 16'h0000, 0, 0,  1'b1, 1'b0, 0};
      vecs[6] = '{8'h7F, 16'h0000, 3, 2,  1'b1, 1'b1, 0};
      vecs[7] = '{8'hFE, 16'hFFFF, 0, 1,  1'b1, 1'b1, 0};

      doReset("reset");

      for (int i = 0; i < 8; i++) begin
         err_before = err_count;
         applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].idl);
         if (vecs[i].exp_write)
            expectWrite($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].rd + 1);
         else
            expectNoWrite($sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d_hold", i), cpu_hold, vecs[i].exp_hold);
         checkOutput($sformatf("vec%0d_err", i), err_count - err_before, vecs[i].exp_err);
      end

      // Start, then a new frame must re-assert the hold on its first edge.
      applyStimulus(8'hFF, 16'h0001, 0, 0);
      checkOutput("start_hold", cpu_hold, 0);
      expectNoWrite("start");
      sendBits({8'h10, 16'h1234}, 23, 23);
      checkOutput("rehold_before_edge", cpu_hold, 0);
      @(negedge clk);
      checkOutput("rehold_at_edge", cpu_hold, 1);
      sendBits({8'h10, 16'h1234}, 22, 0);
      repeat (12) @(negedge clk);
      expectWrite("rehold", 8'h10, 16'h1234, 1);

      // Partial frame abandoned by the serial clock.
      err_before = err_count;
      sendBits({8'h0C, 16'h3456}, 23, 14);
      repeat (1000) @(negedge clk);
      checkOutput("timeout_early", err_count - err_before, 0);
      repeat (40) @(negedge clk);
      checkOutput("timeout_err", err_count - err_before, 1);
      checkOutput("timeout_hold", cpu_hold, 1);
      expectNoWrite("timeout");
      applyStimulus(8'h33, 16'h5555, 1, 0);
      expectWrite("after_timeout", 8'h33, 16'h5555, 2);

      // Serial edge while a write is pending.
      err_before  = err_count;
      ready_delay = 40;
      sendBits({8'h40, 16'hCAFE}, 23, 0);
      n = 0;
      while (mem_we !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("overrun_we_seen", mem_we, 1);
      sendBits(24'hFFFFFF, 0, 0);
      repeat (60) @(negedge clk);
      checkOutput("overrun_err", err_count - err_before, 1);
      expectWrite("overrun", 8'h40, 16'hCAFE, 41);

      // Randomized frames against the model.
      for (int i = 0; i < 30; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rdat = 16'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            ra   = 8'hFF;
            rdat = 16'($urandom_range(0, 2));
         end
         rrd  = $urandom_range(0, 5);
         ridl = $urandom_range(0, 4);
         kind = frameKind(ra, rdat);
         err_before = err_count;
         applyStimulus(ra, rdat, rrd, ridl);
         if (kind == 0)
            expectWrite($sformatf("rnd%0d", i), ra, rdat, rrd + 1);
         else
            expectNoWrite($sformatf("rnd%0d", i));
         checkOutput($sformatf("rnd%0d_hold", i), cpu_hold, (kind == 1) ? 1'b0 : 1'b1);
         checkOutput($sformatf("rnd%0d_err", i), err_count - err_before, (kind == 3) ? 1 : 0);
      end

      // Enough writes to drive the counter into saturation.
      for (int i = 0; i < 260; i++) begin
         ra   = 8'($urandom_range(0, 254));
         rdat = 16'($urandom);
         applyStimulus(ra, rdat, 0, 0);
         expectWrite($sformatf("sat%0d", i), ra, rdat, 1);
      end
      checkOutput("sat_final", words_loaded, 255);

      // Reset in the middle of a frame, then a clean frame.
      sendBits({8'h21, 16'h0F0F}, 23, 12);
      doReset("reset_midframe");
      applyStimulus(8'h21, 16'h0F0F, 0, 0);
      expectWrite("post_midframe", 8'h21, 16'h0F0F, 1);

      // Reset in the middle of a stalled write.
      ready_delay = 50;
      sendBits({8'h44, 16'h7777}, 23, 0);
      n = 0;
      while (mem_we !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midwrite_we_seen", mem_we, 1);
      doReset("reset_midwrite");
      repeat (60) @(negedge clk);
      expectNoWrite("post_midwrite");
      applyStimulus(8'h45, 16'h8888, 0, 0);
      expectWrite("post_reset", 8'h45, 16'h8888, 1);

      checkOutput("we_stable", stable_bad, 0);
      checkOutput("we_only_under_hold", hold_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hmmm_program_loader.md
Name: hmmm_program_loader

Overview:
Serial program loader and memory-port arbiter for the hmmm core. It deserialises address/data frames from the two programming pins, pgrm_addr and pgrm_data. It holds the CPU off the instruction-memory port while loading, writes each word into memory, and releases the CPU on a start command. It sits between the top-level programming pins and the hmmm core's memory write port.

Parameters:
ADDR_W, 8, memory word-address width; the frame address field is ADDR_W bits.
DATA_W, 16, instruction word width; the frame data field is DATA_W bits.
TIMEOUT, 1024, clk cycles without a serial clock edge before a partial frame is discarded.

Ports:
clk  input  1  core clock; all state is on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
pgrm_addr  input  1  serial clock from the pad; asynchronous to clk.
pgrm_data  input  1  serial data from the pad; asynchronous to clk.
cpu_idle  input  1  core is stopped at an instruction boundary while cpu_hold=1.
mem_ready  input  1  memory accepted the current write.
cpu_hold  output  1  high: the loader owns the memory port and the core must stall.
mem_we  output  1  write request; stays high until mem_ready.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  DATA_W  write data.
frame_err  output  1  one-cycle pulse on a bad or dropped frame.
words_loaded  output  8  count of completed writes, saturating at 255.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, frame_err=0, words_loaded=0.
  - All synchronisers, the shift register, the bit counter and the timeout counter clear.
  - Reset mid-frame or mid-write aborts the frame or write with no further side effects.
- Input path:
  - pgrm_addr and pgrm_data each pass through a 2-flop synchroniser.
  - A rising edge is detected on synced pgrm_addr against a third register. The edge pulse lags the pad by 3 clk.
  - On an edge, synced pgrm_data is sampled.
- Frame format: ADDR_W+DATA_W bits (24 at defaults), MSB first. The address comes first, then the data.
- States: IDLE, RUN, SHIFT, WAIT_IDLE, WRITE.
- IDLE (cpu_hold=1): on an edge, shift in the bit, bitcnt=1, go to SHIFT.
- RUN (cpu_hold=0): on an edge, shift in the bit, bitcnt=1, go to SHIFT. cpu_hold rises on the same clock as the state change.
- SHIFT (cpu_hold=1):
  - Each edge shifts in one bit and increments bitcnt.
  - The timeout counter clears on every edge and increments otherwise.
  - When the final bit arrives (bitcnt becomes 24), the frame is decoded on the next cycle:
    - addr = all ones and data = 1: start command. Go to RUN; cpu_hold drops on that transition. No write.
    - addr = all ones and data = 0: stop command. Go to IDLE with no write.
    - addr = all ones with any other data: frame_err pulse, go to IDLE.
    - Any other addr: latch mem_addr/mem_wdata, go to WAIT_IDLE.
  - If the timeout counter reaches TIMEOUT-1: frame_err pulse, discard the shift register and bitcnt, go to IDLE. The hold stays asserted.
- WAIT_IDLE: wait for cpu_idle=1, then go to WRITE with mem_we=1 on entry.
- WRITE:
  - mem_we, mem_addr and mem_wdata stay stable until mem_ready is sampled high.
  - When mem_ready is sampled high: mem_we=0 on the next cycle, words_loaded+1 (saturating at 255), go to IDLE.
  - If mem_ready is already high on the first WRITE cycle, the write completes in 1 cycle.
- Overrun: a serial edge during WAIT_IDLE or WRITE pulses frame_err and the bit is dropped. The pending write still completes.
- Simultaneous events:
  - If a timeout and the final edge occur on the same cycle, the edge wins and the frame is complete.
  - A frame_err from an overrun and one from decode in the same cycle produce one single-cycle pulse.
- Command decode never asserts mem_we. mem_we is never high while cpu_hold=0.

Test Plan:
- Reset state: pulse rst_n low mid-operation -> next cycle cpu_hold=1, mem_we=0, words_loaded=0, state IDLE.
- Single write: send frame addr=0x05, data=0xA1B2 with cpu_idle=1 and mem_ready=1 -> one mem_we pulse with mem_addr=0x05 and mem_wdata=0xA1B2, then words_loaded=1.
- Memory backpressure: same frame with mem_ready held low for 7 cycles -> mem_we high for exactly 8 cycles with address/data stable, then words_loaded=1.
- CPU stall: cpu_idle=0 for 20 cycles after the frame -> no mem_we until cpu_idle rises, then the write proceeds.
- Start and re-hold:
  - Send frame addr=0xFF, data=0x0001 -> cpu_hold=0 and no write.
  - Then a new frame addr=0x10, data=0x1234 -> cpu_hold=1 from the first edge, then the write occurs.
- Errors:
  - Send 10 bits then idle for 1024 cycles -> one frame_err pulse, state IDLE, no write.
  - Send addr=0xFF, data=0x0042 -> frame_err pulse and no write.
  - An edge during WRITE -> frame_err pulse and the pending write still completes.
